// File: rtl/epsilon_stream_pkg.sv
// Shared types and helpers for the epsilon bit-stream producer.
//   state_t    : FSM encoding used by epsilon_stream_source
//   LFSR_TAPS  : Fibonacci tap mask (bit positions 16,14,13,11 -> bits 15,13,12,10)
//   lfsr_step8 : eight shift-left LFSR steps unrolled into one combinational function
package epsilon_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT,
    WAIT_RES,
    DONE
  } state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Each step shifts left and feeds the XOR of the tapped bits into bit 0,
  // so after eight steps the old low byte has moved into the high byte.
  function automatic logic [15:0] lfsr_step8(input logic [15:0] value);
    logic [15:0] v;
    v = value;
    for (int i = 0; i < 8; i++) begin
      v = {v[14:0], ^(v & LFSR_TAPS)};
    end
    return v;
  endfunction

endpackage

// File: rtl/epsilon_stream_source_if.sv
// Handshake bundle between the epsilon stream producer and its environment.
//   master : producer side (epsilon_stream_source)
//   slave  : byte supplier / bit consumer / controller side
// Signals
//   start, src_lfsr            : sequence control
//   byte_dat, byte_vld, byte_rdy : external byte port
//   epsilon_dat, epsilon_vld, epsilon_lz : bit stream toward the consumer
//   is_random_dat, valid_dat   : consumer verdict
//   busy, done, verdict, timeout : status
interface epsilon_stream_source_if;

  logic       start;
  logic       src_lfsr;
  logic [7:0] byte_dat;
  logic       byte_vld;
  logic       byte_rdy;
  logic       epsilon_dat;
  logic       epsilon_vld;
  logic       epsilon_lz;
  logic       is_random_dat;
  logic       valid_dat;
  logic       busy;
  logic       done;
  logic       verdict;
  logic       timeout;

  modport master (
    input  start, src_lfsr, byte_dat, byte_vld, epsilon_lz, is_random_dat, valid_dat,
    output byte_rdy, epsilon_dat, epsilon_vld, busy, done, verdict, timeout
  );

  modport slave (
    output start, src_lfsr, byte_dat, byte_vld, epsilon_lz, is_random_dat, valid_dat,
    input  byte_rdy, epsilon_dat, epsilon_vld, busy, done, verdict, timeout
  );

endinterface

// File: rtl/epsilon_lfsr16.sv
// 16-bit Fibonacci LFSR used as the internal bit source.
// Ports
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset, reloads LFSR_SEED
//   i_load   in   reload LFSR_SEED (sequence start)
//   i_step8  in   advance eight steps in one cycle
//   o_value  out  current LFSR state
module epsilon_lfsr16
  import epsilon_stream_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_step8,
  output logic [15:0] o_value
);

  logic [15:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (rst || i_load) begin
      r_lfsr <= LFSR_SEED;
    end else if (i_step8) begin
      r_lfsr <= lfsr_step8(r_lfsr);
    end
  end

  assign o_value = r_lfsr;

endmodule

// File: rtl/epsilon_stream_source.sv
// Producer end of the epsilon bit stream. Serializes SEQ_LEN bits, MSB first
// per byte, one bit per consumer epsilon_lz pulse, from either the external
// byte port or the internal LFSR, then waits for the consumer verdict.
// Ports
//   clk  in  clock, rising edge
//   rst  in  synchronous active-high reset
//   bus  epsilon_stream_source_if.master: control, byte port, bit stream, verdict, status
module epsilon_stream_source
  import epsilon_stream_pkg::*;
#(
  parameter int          SEQ_LEN   = 128,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          TIMEOUT   = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  epsilon_stream_source_if.master  bus
);

  localparam int BCW = $clog2(SEQ_LEN + 1);
  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(SEQ_LEN - 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  logic             r_src_lfsr;
  logic [7:0]       r_shreg;
  logic [BCW-1:0]   r_bit_cnt;
  logic [WCW-1:0]   r_wait_cnt;
  logic             r_eps_dat;
  logic             r_eps_vld;
  logic             r_verdict;
  logic             r_timeout;

  logic             w_byte_rdy;
  logic             w_busy;
  logic             w_done;
  logic             w_lfsr_load;
  logic             w_lfsr_step;
  logic             w_take;
  logic             w_byte_end;
  logic             w_last_bit;
  logic [15:0]      w_lfsr;
  logic [7:0]       w_unused_lfsr_lo;

  epsilon_lfsr16 #(
    .LFSR_SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_lfsr_load),
    .i_step8 (w_lfsr_step),
    .o_value (w_lfsr)
  );

  // Only the high byte is ever serialized; the low byte feeds the LFSR itself.
  assign w_unused_lfsr_lo = w_lfsr[7:0];

  // bit_cnt counts from 0, so its low three bits give the position in the byte.
  assign w_byte_end = (r_bit_cnt[2:0] == 3'b111);
  assign w_last_bit = (r_bit_cnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: if (bus.start) w_next = FETCH;
      FETCH:      if (r_src_lfsr || bus.byte_vld) w_next = SHIFT;
      SHIFT:      if (w_take && w_byte_end) w_next = w_last_bit ? WAIT_RES : FETCH;
      WAIT_RES:   if (bus.valid_dat || (r_wait_cnt == WAIT_LAST)) w_next = DONE;
      default:    w_next = IDLE;
    endcase
  end

  always_comb begin
    w_byte_rdy  = 1'b0;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    w_lfsr_load = 1'b0;
    w_lfsr_step = 1'b0;
    w_take      = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy      = 1'b0;
        w_lfsr_load = bus.start;
      end
      DONE: begin
        w_busy      = 1'b0;
        w_done      = 1'b1;
        w_lfsr_load = bus.start;
      end
      FETCH: begin
        w_byte_rdy  = !r_src_lfsr;
        w_lfsr_step = r_src_lfsr;
      end
      SHIFT:   w_take = bus.epsilon_lz;
      default: ;
    endcase
  end

  // Control, counters and registered stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_src_lfsr <= 1'b0;
      r_bit_cnt  <= '0;
      r_wait_cnt <= '0;
      r_eps_dat  <= 1'b0;
      r_eps_vld  <= 1'b0;
      r_verdict  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_src_lfsr <= bus.src_lfsr;
            r_bit_cnt  <= '0;
            r_timeout  <= 1'b0;
            r_verdict  <= 1'b0;
          end
        end
        FETCH: begin
          // epsilon_dat/vld hold while stalled here so the consumer sees a steady bit.
          if (r_src_lfsr) begin
            r_eps_dat <= w_lfsr[15];
            r_eps_vld <= 1'b1;
          end else if (bus.byte_vld) begin
            r_eps_dat <= bus.byte_dat[7];
            r_eps_vld <= 1'b1;
          end
        end
        SHIFT: begin
          if (w_take) begin
            r_bit_cnt <= r_bit_cnt + BCW'(1);
            if (w_byte_end) begin
              r_wait_cnt <= '0;
              if (w_last_bit) r_eps_vld <= 1'b0;
            end else begin
              r_eps_dat <= r_shreg[6];
            end
          end
        end
        WAIT_RES: begin
          // A verdict arriving on the final wait cycle takes precedence over timeout.
          if (bus.valid_dat) begin
            r_verdict <= bus.is_random_dat;
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_timeout <= 1'b1;
            r_verdict <= 1'b0;
          end else begin
            r_wait_cnt <= r_wait_cnt + WCW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Byte shift register: pure data, loaded in FETCH and shifted per consumed bit.
  always_ff @(posedge clk) begin
    if (w_lfsr_step) begin
      r_shreg <= w_lfsr[15:8];
    end else if (w_byte_rdy && bus.byte_vld) begin
      r_shreg <= bus.byte_dat;
    end else if (w_take) begin
      r_shreg <= {r_shreg[6:0], 1'b0};
    end
  end

  assign bus.byte_rdy    = w_byte_rdy;
  assign bus.epsilon_dat = r_eps_dat;
  assign bus.epsilon_vld = r_eps_vld;
  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.verdict     = r_verdict;
  assign bus.timeout     = r_timeout;

endmodule

// File: tb/tb_epsilon_stream_source.sv
// Self-checking bench for epsilon_stream_source (SEQ_LEN=16, TIMEOUT=16).
// Expected stream bits and verdicts are queued by the stimulus and popped by
// independent monitor processes whenever the DUT consumes a bit or enters DONE.
module tb_epsilon_stream_source;
  import epsilon_stream_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  epsilon_stream_source_if sif ();

  epsilon_stream_source #(
    .SEQ_LEN   (16),
    .LFSR_SEED (16'hACE1),
    .TIMEOUT   (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  typedef struct {
    logic [7:0] b;
    int         stall;
  } feed_t;

  typedef struct {
    logic verdict;
    logic timeout;
  } res_t;

  feed_t feed_q[$];
  logic  exp_bits[$];
  res_t  exp_res[$];
  int    total = 0;
  int    bad   = 0;
  logic  prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_bits.push_back(b[i]);
  endtask

  task automatic add_feed(input logic [7:0] b, input int stall);
    feed_t f;
    f.b = b;
    f.stall = stall;
    feed_q.push_back(f);
  endtask

  task automatic add_res(input logic v, input logic t);
    res_t r;
    r.verdict = v;
    r.timeout = t;
    exp_res.push_back(r);
  endtask

  task automatic pulse_start(input logic lfsr);
    @(posedge clk); #1;
    sif.src_lfsr = lfsr;
    sif.start    = 1'b1;
    @(posedge clk); #1;
    sif.start    = 1'b0;
  endtask

  task automatic run_to_wait(output int fetches);
    int n;
    fetches = 0;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (dut.r_state == FETCH) fetches++;
      if (dut.r_state == WAIT_RES) break;
    end
    if (n >= 300) begin
      total++;
      bad++;
      $display("FAIL reach_wait_res: state %0d after 300 cycles, want %0d", dut.r_state, WAIT_RES);
    end
  endtask

  // Bit monitor: a bit is consumed at the next edge when lz is high in SHIFT.
  always @(negedge clk) begin
    if (!rst && sif.epsilon_vld && sif.epsilon_lz && dut.r_state == SHIFT) begin
      if (exp_bits.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_bit: got bit %0b, want no bit", sif.epsilon_dat);
      end else begin
        logic e;
        e = exp_bits.pop_front();
        check("stream_bit", sif.epsilon_dat, e);
      end
    end
  end

  // Verdict monitor: compares status on each entry into DONE.
  always @(negedge clk) begin
    if (!rst && sif.done && !prev_done) begin
      if (exp_res.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_done: got verdict=%0b timeout=%0b, want no result", sif.verdict, sif.timeout);
      end else begin
        res_t r;
        r = exp_res.pop_front();
        check("sb_verdict", sif.verdict, r.verdict);
        check("sb_timeout", sif.timeout, r.timeout);
      end
    end
    prev_done = rst ? 1'b0 : sif.done;
  end

  // Byte supplier: presents queued bytes in FETCH after the requested stall.
  initial begin : feeder
    int stall_cnt;
    stall_cnt    = 0;
    sif.byte_vld = 1'b0;
    sif.byte_dat = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (sif.byte_vld && !sif.byte_rdy) sif.byte_vld = 1'b0;
      if (!sif.byte_vld && sif.byte_rdy && feed_q.size() > 0) begin
        if (stall_cnt < feed_q[0].stall) begin
          stall_cnt++;
        end else begin
          sif.byte_dat = feed_q[0].b;
          sif.byte_vld = 1'b1;
          void'(feed_q.pop_front());
          stall_cnt = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal;
  end

  initial begin : stim
    int  nf;
    int  k;
    logic found;

    rst               = 1'b1;
    sif.start         = 1'b0;
    sif.src_lfsr      = 1'b0;
    sif.epsilon_lz    = 1'b0;
    sif.is_random_dat = 1'b0;
    sif.valid_dat     = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_byte_rdy", sif.byte_rdy, 0);
    check("rst_eps_dat", sif.epsilon_dat, 0);
    check("rst_eps_vld", sif.epsilon_vld, 0);
    check("rst_busy", sif.busy, 0);
    check("rst_done", sif.done, 0);
    check("rst_verdict", sif.verdict, 0);
    check("rst_timeout", sif.timeout, 0);
    check("rst_state", dut.r_state, IDLE);
    @(posedge clk); #1;
    rst = 1'b0;

    // Byte source: A5 then 3C, lz held high.
    push_byte(8'hA5);
    push_byte(8'h3C);
    add_feed(8'hA5, 0);
    add_feed(8'h3C, 0);
    sif.epsilon_lz = 1'b1;
    pulse_start(1'b0);
    check("t1_busy", sif.busy, 1);
    check("t1_byte_rdy", sif.byte_rdy, 1);
    check("t1_vld_first_fetch", sif.epsilon_vld, 0);
    run_to_wait(nf);
    check("t1_bits_left", exp_bits.size(), 0);
    check("t1_vld_wait", sif.epsilon_vld, 0);
    check("t1_busy_wait", sif.busy, 1);

    // Verdict on the third WAIT_RES cycle.
    repeat (2) @(posedge clk);
    #1;
    add_res(1'b1, 1'b0);
    sif.valid_dat     = 1'b1;
    sif.is_random_dat = 1'b1;
    @(posedge clk); #1;
    sif.valid_dat     = 1'b0;
    sif.is_random_dat = 1'b0;
    @(negedge clk);
    check("t2_done", sif.done, 1);
    check("t2_verdict", sif.verdict, 1);
    check("t2_timeout", sif.timeout, 0);
    check("t2_busy", sif.busy, 0);

    // LFSR source restarted from DONE: bytes AC then E1, two fetch cycles.
    push_byte(8'hAC);
    push_byte(8'hE1);
    pulse_start(1'b1);
    check("t3_verdict_cleared", sif.verdict, 0);
    check("t3_done_cleared", sif.done, 0);
    check("t3_byte_rdy_lfsr", sif.byte_rdy, 0);
    run_to_wait(nf);
    check("t3_fetch_cycles", nf, 2);
    check("t3_bits_left", exp_bits.size(), 0);

    // No verdict: timeout exactly 16 cycles after WAIT_RES entry.
    add_res(1'b0, 1'b1);
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("t4_not_early", sif.done, 0);
    @(posedge clk);
    @(negedge clk);
    check("t4_done", sif.done, 1);
    check("t4_timeout", sif.timeout, 1);
    check("t4_verdict", sif.verdict, 0);

    // Restart with byte source; second byte stalled 20 cycles.
    push_byte(8'h5B);
    push_byte(8'hC3);
    add_feed(8'h5B, 0);
    add_feed(8'hC3, 20);
    pulse_start(1'b0);
    check("t4_timeout_cleared", sif.timeout, 0);
    check("t4_restart_busy", sif.busy, 1);
    found = 1'b0;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (dut.r_state == FETCH && dut.r_bit_cnt == 8) begin
        found = 1'b1;
        break;
      end
    end
    check("t5_reached_stall", found, 1);
    check("t5_vld_stall_start", sif.epsilon_vld, 1);
    check("t5_dat_stall_start", sif.epsilon_dat, 1);
    repeat (10) @(negedge clk);
    check("t5_bitcnt_frozen", dut.r_bit_cnt, 8);
    check("t5_vld_held", sif.epsilon_vld, 1);
    check("t5_dat_held", sif.epsilon_dat, 1);
    check("t5_state_fetch", dut.r_state, FETCH);
    run_to_wait(nf);
    check("t5_bits_left", exp_bits.size(), 0);

    // Verdict on the last wait cycle wins over timeout.
    add_res(1'b1, 1'b0);
    repeat (15) @(posedge clk);
    #1;
    sif.valid_dat     = 1'b1;
    sif.is_random_dat = 1'b1;
    @(posedge clk); #1;
    sif.valid_dat     = 1'b0;
    sif.is_random_dat = 1'b0;
    @(negedge clk);
    check("t5_edge_done", sif.done, 1);
    check("t5_edge_timeout", sif.timeout, 0);
    check("t5_edge_verdict", sif.verdict, 1);

    // Reset in SHIFT at bit 5, then replay the LFSR sequence from bit 0.
    push_byte(8'hAC);
    push_byte(8'hE1);
    pulse_start(1'b1);
    found = 1'b0;
    for (k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (dut.r_state == SHIFT && dut.r_bit_cnt == 5) begin
        rst            = 1'b1;
        sif.epsilon_lz = 1'b0;
        found          = 1'b1;
        break;
      end
    end
    check("t6_reached_bit5", found, 1);
    @(negedge clk);
    check("t6_still_shift", dut.r_state, SHIFT);
    @(posedge clk);
    @(negedge clk);
    check("t6_state", dut.r_state, IDLE);
    check("t6_eps_vld", sif.epsilon_vld, 0);
    check("t6_eps_dat", sif.epsilon_dat, 0);
    check("t6_busy", sif.busy, 0);
    check("t6_byte_rdy", sif.byte_rdy, 0);
    check("t6_bit_cnt", dut.r_bit_cnt, 0);
    check("t6_lfsr_seed", dut.u_lfsr.o_value, 16'hACE1);
    check("t6_bits_consumed", exp_bits.size(), 11);
    exp_bits.delete();
    @(posedge clk); #1;
    rst            = 1'b0;
    sif.epsilon_lz = 1'b1;
    push_byte(8'hAC);
    push_byte(8'hE1);
    pulse_start(1'b1);
    run_to_wait(nf);
    check("t6_fetch_cycles", nf, 2);
    check("t6_bits_left", exp_bits.size(), 0);
    add_res(1'b1, 1'b0);
    @(posedge clk); #1;
    sif.valid_dat     = 1'b1;
    sif.is_random_dat = 1'b1;
    @(posedge clk); #1;
    sif.valid_dat     = 1'b0;
    sif.is_random_dat = 1'b0;
    @(negedge clk);
    check("t6_done", sif.done, 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("results_left", exp_res.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
